// File: rtl/uart_stream_fifo.sv
// UART with Avalon-ST receive source and transmit sink, each side buffered by a show-ahead FIFO.
// Configurable frame (data/parity/stop), baud divisor, FIFO depth, per-word error tag and overrun pulse.

module uart_stream_fifo_buf #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a push to a full FIFO may proceed alongside it.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end
endmodule

module uart_stream_fifo #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_error,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_error,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);
    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

    function automatic logic par_calc(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // Reset: asserted asynchronously, released on a clock edge.
    logic rst_meta_q, rst_sync_q, rst_n;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n = rst_sync_q;

    // ---------------- TX side ----------------
    logic                 init_q;
    logic                 tx_push_c, tx_pop_c, tx_empty_c, tx_full_c;
    logic [DATA_BITS-1:0] tx_head_c;
    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;

    assign tx_ready  = init_q && !tx_full_c;
    assign tx_push_c = tx_valid && tx_ready && !tx_error;
    assign uart_txd  = txd_q;

    uart_stream_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (rst_n),
        .push_i  (tx_push_c),
        .data_i  (tx_data),
        .pop_i   (tx_pop_c),
        .data_o  (tx_head_c),
        .empty_o (tx_empty_c),
        .full_o  (tx_full_c)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop_c   = 1'b0;
        if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - CW'(1);
        case (tx_state_q)
            TX_IDLE: tx_pop_c = !tx_empty_c;
            TX_START: if (tx_cnt_q == '0) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = CNT_FULL;
                tx_bit_d   = '0;
                txd_d      = tx_shift_q[0];
            end
            TX_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = CNT_FULL;
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == BIT_LAST) begin
                    tx_bit_d = '0;
                    if (PARITY != 0) begin
                        tx_state_d = TX_PARITY;
                        txd_d      = tx_par_q;
                    end else begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                    txd_d    = tx_shift_q[1];
                end
            end
            TX_PARITY: if (tx_cnt_q == '0) begin
                tx_state_d = TX_STOP;
                tx_cnt_d   = CNT_FULL;
                txd_d      = 1'b1;
            end
            TX_STOP: if (tx_cnt_q == '0) begin
                if (tx_bit_q == STOP_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_pop_c   = !tx_empty_c;
                end else begin
                    tx_bit_d = tx_bit_q + BW'(1);
                    tx_cnt_d = CNT_FULL;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // A pop always starts a frame, which lets the next START follow the last STOP clock directly.
        if (tx_pop_c) begin
            tx_state_d = TX_START;
            tx_cnt_d   = CNT_FULL;
            tx_shift_d = tx_head_c;
            tx_par_d   = par_calc(tx_head_c);
            txd_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            init_q     <= 1'b1;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------- RX side ----------------
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_push_q, rx_push_d;
    logic [DATA_BITS:0]   rx_word_q, rx_word_d;
    logic                 rx_overrun_q;
    logic                 rx_pop_c, rx_empty_c, rx_full_c;
    logic [DATA_BITS:0]   rx_head_c;

    assign rx_valid   = !rx_empty_c;
    assign rx_pop_c   = rx_valid && rx_ready;
    assign rx_error   = rx_head_c[DATA_BITS];
    assign rx_data    = rx_head_c[DATA_BITS-1:0];
    assign rx_overrun = rx_overrun_q;

    uart_stream_fifo_buf #(.W(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (rst_n),
        .push_i  (rx_push_q),
        .data_i  (rx_word_q),
        .pop_i   (rx_pop_c),
        .data_o  (rx_head_c),
        .empty_o (rx_empty_c),
        .full_o  (rx_full_c)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_word_d  = rx_word_q;
        rx_push_d  = 1'b0;
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CW'(1);
        case (rx_state_q)
            RX_IDLE: if (rxd_prev_q && !rxd_sync_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = CNT_HALF;
            end
            RX_START: if (rx_cnt_q == '0) begin
                if (rxd_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = CNT_FULL;
                    rx_bit_d   = '0;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = CNT_FULL;
                rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                else                      rx_bit_d   = rx_bit_q + BW'(1);
            end
            RX_PARITY: if (rx_cnt_q == '0) begin
                rx_perr_d  = (rxd_sync_q != par_calc(rx_shift_q));
                rx_state_d = RX_STOP;
                rx_cnt_d   = CNT_FULL;
            end
            // Only the first stop bit is checked; a low line here is a framing error or a break.
            RX_STOP: if (rx_cnt_q == '0) begin
                rx_push_d  = 1'b1;
                rx_word_d  = {rx_perr_q | !rxd_sync_q, rx_shift_q};
                rx_state_d = rxd_sync_q ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: if (rxd_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rxd_prev_q   <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_perr_q    <= 1'b0;
            rx_push_q    <= 1'b0;
            rx_word_q    <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            rxd_meta_q   <= uart_rxd;
            rxd_sync_q   <= rxd_meta_q;
            rxd_prev_q   <= rxd_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_perr_q    <= rx_perr_d;
            rx_push_q    <= rx_push_d;
            rx_word_q    <= rx_word_d;
            rx_overrun_q <= rx_push_q && rx_full_c && !rx_pop_c;
        end
    end
endmodule

// File: tb/tb_uart_stream_fifo.sv
// Directed bench for uart_stream_fifo: TX bit timing, loopback ordering, parity, overrun, discard, reset.
// Received words are checked against a queue of expected {error,data} entries.

module tb_uart_stream_fifo;
    logic       clk = 1'b0;
    logic       reset_reset_n;
    logic       rxd_drv, loop_en, uart_rxd, uart_txd;
    logic [7:0] tx_data;
    logic       tx_error, tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_error, rx_valid, rx_ready, rx_overrun;

    logic       rxd_p, uart_txd_p, tx_ready_p;
    logic [7:0] rx_data_p;
    logic       rx_error_p, rx_valid_p, rx_ready_p, rx_overrun_p;

    int         errors = 0;
    int         checks = 0;
    int         ovr_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    always #5 clk = ~clk;
    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    uart_stream_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk_clk(clk), .reset_reset_n(reset_reset_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .tx_data(tx_data), .tx_error(tx_error), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_error(rx_error), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun)
    );

    uart_stream_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
        .clk_clk(clk), .reset_reset_n(reset_reset_n), .uart_rxd(rxd_p), .uart_txd(uart_txd_p),
        .tx_data(8'h00), .tx_error(1'b0), .tx_valid(1'b0), .tx_ready(tx_ready_p),
        .rx_data(rx_data_p), .rx_error(rx_error_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
        .rx_overrun(rx_overrun_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        int n = 0;
        tx_data  = d;
        tx_error = e;
        tx_valid = 1'b1;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        check("push_ready", 32'(tx_ready), 32'(1));
        tick();
        tx_valid = 1'b0;
        tx_error = 1'b0;
    endtask

    task automatic drive_bit(input bit to_p, input logic v);
        if (to_p) rxd_p = v;
        else      rxd_drv = v;
        repeat (16) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic par_bit, input bit to_p);
        drive_bit(to_p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(to_p, d[i]);
        if (with_par) drive_bit(to_p, par_bit);
        drive_bit(to_p, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'(0));
    endtask

    // Scoreboard: every source transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (reset_reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 32'(rx_valid), 32'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_word", 32'({rx_error, rx_data}), 32'(mon_exp));
            end
        end
        if (rx_overrun) ovr_cnt++;
    end

    initial begin
        logic [7:0] tx_byte;
        logic       exp_bit;
        int         n, lows, ovr_base, seen;
        logic [7:0] words[6];

        reset_reset_n = 1'b0;
        rxd_drv = 1'b1; rxd_p = 1'b1; loop_en = 1'b0;
        tx_data = '0; tx_error = 1'b0; tx_valid = 1'b0;
        rx_ready = 1'b0; rx_ready_p = 1'b0;
        repeat (4) tick();
        check("rst_txd", 32'(uart_txd), 32'(1));
        check("rst_tx_ready", 32'(tx_ready), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_rx_data", 32'({rx_error, rx_data}), 32'(0));
        check("rst_overrun", 32'(rx_overrun), 32'(0));
        reset_reset_n = 1'b1;
        tick();
        check("rel_tx_ready_low", 32'(tx_ready), 32'(0));
        check("rel_txd", 32'(uart_txd), 32'(1));
        n = 0;
        while (!tx_ready && n < 10) begin tick(); n++; end
        check("rel_tx_ready_high", 32'(tx_ready), 32'(1));

        // 1: single frame bit timing, 0xA5 LSB first
        tx_byte = 8'hA5;
        push(tx_byte, 1'b0);
        n = 0;
        while (uart_txd && n < 50) begin tick(); n++; end
        check("tx_start_seen", 32'(uart_txd), 32'(0));
        for (int i = 0; i < 160; i++) begin
            exp_bit = (i < 16) ? 1'b0 : (i >= 144) ? 1'b1 : tx_byte[(i - 16) / 16];
            check("tx_bit", 32'(uart_txd), 32'(exp_bit));
            tick();
        end
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (!uart_txd) lows++;
            tick();
        end
        check("tx_idle_after", 32'(lows), 32'(0));

        // 2: loopback, three back-to-back words
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h3C});
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        push(8'h3C, 1'b0);
        drain("loop_drain");
        repeat (20) tick();
        loop_en = 1'b0;

        // 3: even parity on the second instance
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (4) tick();
        check("par_bad_valid", 32'(rx_valid_p), 32'(1));
        check("par_bad_word", 32'({rx_error_p, rx_data_p}), 32'({1'b1, 8'h07}));
        rx_ready_p = 1'b1; tick(); rx_ready_p = 1'b0;
        check("par_popped", 32'(rx_valid_p), 32'(0));
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        check("par_good_word", 32'({rx_valid_p, rx_error_p, rx_data_p}), 32'({2'b10, 8'h07}));
        rx_ready_p = 1'b1; tick(); rx_ready_p = 1'b0;

        // 4: six frames into a four-deep FIFO with the sink stalled
        rx_ready = 1'b0;
        ovr_base = ovr_cnt;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back({1'b0, words[i]});
            send_frame(words[i], 1'b0, 1'b0, 1'b0);
        end
        repeat (4) tick();
        check("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'(2));
        check("ovr_held_valid", 32'(rx_valid), 32'(1));
        rx_ready = 1'b1;
        drain("ovr_drain");
        tick();
        check("ovr_empty", 32'(rx_valid), 32'(0));

        // 5: error-tagged sink word is discarded; short glitch on rxd is rejected
        push(8'h5A, 1'b1);
        check("err_ready", 32'(tx_ready), 32'(1));
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (!uart_txd) lows++;
            tick();
        end
        check("err_txd_idle", 32'(lows), 32'(0));
        rxd_drv = 1'b0; repeat (2) tick(); rxd_drv = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (rx_valid) seen++;
            tick();
        end
        check("glitch_no_valid", 32'(seen), 32'(0));

        // 6: reset in the middle of TX and RX frames
        push(8'h5A, 1'b0);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        reset_reset_n = 1'b0;
        rxd_drv = 1'b1;
        #1;
        check("mid_rst_txd", 32'(uart_txd), 32'(1));
        check("mid_rst_rx_valid", 32'(rx_valid), 32'(0));
        check("mid_rst_tx_ready", 32'(tx_ready), 32'(0));
        repeat (3) tick();
        reset_reset_n = 1'b1;
        n = 0;
        while (!tx_ready && n < 10) begin tick(); n++; end
        check("post_rst_ready", 32'(tx_ready), 32'(1));
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            if (!uart_txd) lows++;
            tick();
        end
        check("post_rst_tx_fifo_empty", 32'(lows), 32'(0));
        check("post_rst_rx_empty", 32'(rx_valid), 32'(0));
        loop_en = 1'b1;
        exp_q.push_back({1'b0, 8'hC3});
        push(8'hC3, 1'b0);
        drain("post_rst_frame");
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
